// File: rtl/pipe_pkg.sv
// Shared types and helpers for the skid-buffered pipeline stage.
package pipe_pkg;

  // Occupancy of the stage: nothing held, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } pipe_state_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones once reached.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per cycle with inc high; reset clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (inc) count <= W'(sat_inc(64'(count), W));
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry for full throughput under back-pressure, flush-to-bubble, and
// saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state_q, state_d;
  logic              push, pop;
  logic              skid_load;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              stall_inc, bubble_inc;

  assign out_valid = (state_q != S_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  // A flushed input is never accepted; a pop in a flush cycle still completes downstream.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and main-entry load; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_load   = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d     = S_FULL;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      S_FULL: begin
        if (push && pop) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (push && (SKID != 0)) begin
          state_d   = S_SKID;
          skid_load = 1'b1;
        end else if (pop) begin
          // ctrl reads as zero whenever the stage is empty
          state_d     = S_EMPTY;
          main_ctrl_d = '0;
        end
      end
      S_SKID: begin
        if (pop) begin
          state_d     = S_FULL;
          main_ctrl_d = skid_ctrl;
          main_data_d = skid_data;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_load   = 1'b0;
    end
  end

  // Main entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] ctrl_q;
      logic [DATA_W-1:0] data_q;
      logic              rdy_q;

      // Skid entry catches the word accepted while main is stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctrl_q <= '0;
          data_q <= '0;
        end else if (flush) begin
          ctrl_q <= '0;
          data_q <= '0;
        end else if (skid_load) begin
          ctrl_q <= in_ctrl;
          data_q <= in_data;
        end
      end

      // Registered ready: low only while both entries are occupied, so
      // out_ready never reaches in_ready combinationally.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b1;
        else     rdy_q <= (state_d != S_SKID);
      end

      assign skid_ctrl = ctrl_q;
      assign skid_data = data_q;
      assign in_ready  = rdy_q;
    end else begin : g_noskid
      logic unused_skid_load;
      assign unused_skid_load = skid_load;
      assign skid_ctrl        = '0;
      assign skid_data        = '0;
      assign in_ready         = ~out_valid | out_ready;
    end
  endgenerate

  assign stall_inc  = out_valid & ~out_ready;
  assign bubble_inc = ~out_valid;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1/CNT_W=16 instance and one
// SKID=0/CNT_W=3 instance, each tracked by a queue-based occupancy model.
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b0;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [15:0]   a_stall_cnt, a_bubble_cnt;

  logic          b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b0;
  logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [DW-1:0] b_in_data = '0, b_out_data;
  logic [2:0]    b_stall_cnt, b_bubble_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
  );

  // Reference model: a FIFO of held words with a capacity of 2 (A) or 1 (B).
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  word_t       qa[$];
  word_t       qb[$];
  logic [15:0] a_stall = '0, a_bubble = '0;
  logic [2:0]  b_stall = '0, b_bubble = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      a_stall  <= '0;
      a_bubble <= '0;
    end else begin
      if (qa.size() > 0 && !a_out_ready && a_stall != '1) a_stall <= a_stall + 1'b1;
      if (qa.size() == 0 && a_bubble != '1) a_bubble <= a_bubble + 1'b1;
      if (a_flush) qa.delete();
      else if (a_in_valid && qa.size() < 2) begin
        if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
        qa.push_back(word_t'({a_in_ctrl, a_in_data}));
      end else if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete();
      b_stall  <= '0;
      b_bubble <= '0;
    end else begin
      if (qb.size() > 0 && !b_out_ready && b_stall != '1) b_stall <= b_stall + 1'b1;
      if (qb.size() == 0 && b_bubble != '1) b_bubble <= b_bubble + 1'b1;
      if (b_flush) qb.delete();
      else if (b_in_valid && (qb.size() == 0 || b_out_ready)) begin
        if (qb.size() > 0) void'(qb.pop_front());
        qb.push_back(word_t'({b_in_ctrl, b_in_data}));
      end else if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
    end
  end

  function automatic bit ea_valid(); return qa.size() > 0; endfunction
  function automatic bit ea_ready(); return qa.size() < 2; endfunction
  function automatic logic [CW-1:0] ea_ctrl(); return (qa.size() > 0) ? qa[0].c : '0; endfunction
  function automatic logic [DW-1:0] ea_data(); return (qa.size() > 0) ? qa[0].d : '0; endfunction
  function automatic bit eb_valid(); return qb.size() > 0; endfunction
  function automatic bit eb_ready(); return qb.size() == 0 || b_out_ready; endfunction
  function automatic logic [CW-1:0] eb_ctrl(); return (qb.size() > 0) ? qb[0].c : '0; endfunction
  function automatic logic [DW-1:0] eb_data(); return (qb.size() > 0) ? qb[0].d : '0; endfunction

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_ctrl, a_out_data} !== {1'b1 ^ 1'b1, 1'b1, 16'h0, 32'h0}) begin
      failures++; $display("FAIL reset_a got v=%0b r=%0b c=%0h d=%0h exp v=0 r=1 c=0 d=0", a_out_valid, a_in_ready, a_out_ctrl, a_out_data);
    end
    checks++;
    if ({a_stall_cnt, a_bubble_cnt} !== 32'h0) begin
      failures++; $display("FAIL reset_a_cnt got stall=%0d bubble=%0d exp 0 0", a_stall_cnt, a_bubble_cnt);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_out_ctrl, b_out_data, b_stall_cnt, b_bubble_cnt} !== {1'b0, 1'b1, 16'h0, 32'h0, 6'h0}) begin
      failures++; $display("FAIL reset_b got v=%0b r=%0b c=%0h s=%0d b=%0d exp v=0 r=1 c=0 s=0 b=0", b_out_valid, b_in_ready, b_out_ctrl, b_stall_cnt, b_bubble_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] bub1;
    bub1 = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_in_valid  = (i < 5);
      a_in_ctrl   = 16'(i + 1);
      a_in_data   = 32'((i + 1) * 16);
      a_out_ready = 1'b1;
      #1;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_ctrl} !== {ea_valid(), 1'b1, ea_ctrl()}) begin
        failures++; $display("FAIL stream_model i=%0d got v=%0b r=%0b c=%0h exp v=%0b r=1 c=%0h", i, a_out_valid, a_in_ready, a_out_ctrl, ea_valid(), ea_ctrl());
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 16'(i), 32'(i * 16)}) begin
          failures++; $display("FAIL stream_order i=%0d got v=%0b c=%0h d=%0h exp v=1 c=%0h d=%0h", i, a_out_valid, a_out_ctrl, a_out_data, i, i * 16);
        end
      end
      if (i == 1) bub1 = a_bubble_cnt;
      if (i == 6) begin
        checks++;
        if (a_bubble_cnt !== bub1) begin
          failures++; $display("FAIL stream_bubble got=%0d exp=%0d", a_bubble_cnt, bub1);
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] items[3];
    logic [CW-1:0] seen[$];
    logic [15:0]   st0;
    bit            pat[7];
    int            k;
    items = '{16'h00A, 16'h00B, 16'h00C};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    k     = 0;
    st0   = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_in_valid  = (k < 3);
      a_in_ctrl   = (k < 3) ? items[k] : '0;
      a_in_data   = $urandom;
      a_out_ready = pat[i];
      #1;
      if (i == 0) st0 = a_stall_cnt;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_ctrl} !== {ea_valid(), ea_ready(), ea_ctrl()}) begin
        failures++; $display("FAIL bp_model i=%0d got v=%0b r=%0b c=%0h exp v=%0b r=%0b c=%0h", i, a_out_valid, a_in_ready, a_out_ctrl, ea_valid(), ea_ready(), ea_ctrl());
      end
      checks++;
      if (a_in_ready !== !(i == 2 || i == 3)) begin
        failures++; $display("FAIL bp_in_ready i=%0d got=%0b exp=%0b", i, a_in_ready, !(i == 2 || i == 3));
      end
      if (a_out_valid && a_out_ready) seen.push_back(a_out_ctrl);
      if (a_in_valid && a_in_ready) k++;
    end
    a_in_valid = 1'b0;
    checks++;
    if (a_stall_cnt - st0 !== 16'd2) begin
      failures++; $display("FAIL bp_stall got=%0d exp=2", a_stall_cnt - st0);
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 16'h00A || seen[1] !== 16'h00B || seen[2] !== 16'h00C) begin
      failures++; $display("FAIL bp_order got=%p exp=A,B,C", seen);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] seen[$];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_in_valid  = (i <= 3);
      a_in_ctrl   = 16'h0A0 + 16'(i);
      a_in_data   = 32'hD0 + 32'(i);
      a_flush     = (i == 2);
      a_out_ready = (i == 0 || i >= 3);
      #1;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_ctrl} !== {ea_valid(), ea_ready(), ea_ctrl()}) begin
        failures++; $display("FAIL flush_model i=%0d got v=%0b r=%0b c=%0h exp v=%0b r=%0b c=%0h", i, a_out_valid, a_in_ready, a_out_ctrl, ea_valid(), ea_ready(), ea_ctrl());
      end
      if (i == 3) begin
        checks++;
        if ({a_out_valid, a_in_ready, a_out_ctrl, a_out_data} !== {1'b0, 1'b1, 16'h0, 32'h0}) begin
          failures++; $display("FAIL flush_bubble got v=%0b r=%0b c=%0h d=%0h exp v=0 r=1 c=0 d=0", a_out_valid, a_in_ready, a_out_ctrl, a_out_data);
        end
      end
      if (a_out_valid && a_out_ready) seen.push_back(a_out_ctrl);
    end
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
    checks++;
    if (seen.size() != 1 || seen[0] !== 16'h0A3) begin
      failures++; $display("FAIL flush_after got=%p exp=only 0a3", seen);
    end
  endtask

  task automatic test_skid0();
    logic [CW-1:0] seen[$];
    int            k;
    k = 0;
    for (int i = 0; i < 30 && seen.size() < 6; i++) begin
      @(negedge clk);
      b_in_valid  = (k < 6);
      b_in_ctrl   = 16'(32 + k);
      b_in_data   = $urandom;
      b_out_ready = (i < 12) ? i[0] : 1'b1;
      #1;
      checks++;
      if (b_in_ready !== (~b_out_valid | b_out_ready) || b_in_ready !== eb_ready()) begin
        failures++; $display("FAIL skid0_ready i=%0d got=%0b exp=%0b", i, b_in_ready, eb_ready());
      end
      checks++;
      if ({b_out_valid, b_out_ctrl} !== {eb_valid(), eb_ctrl()} || (eb_valid() && b_out_data !== eb_data())) begin
        failures++; $display("FAIL skid0_model i=%0d got v=%0b c=%0h exp v=%0b c=%0h", i, b_out_valid, b_out_ctrl, eb_valid(), eb_ctrl());
      end
      if (b_out_valid && b_out_ready) seen.push_back(b_out_ctrl);
      if (b_in_valid && b_in_ready) k++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    checks++;
    if (seen.size() != 6) begin
      failures++; $display("FAIL skid0_count got=%0d exp=6", seen.size());
    end
    for (int j = 0; j < seen.size(); j++) begin
      checks++;
      if (seen[j] !== 16'(32 + j)) begin
        failures++; $display("FAIL skid0_order j=%0d got=%0h exp=%0h", j, seen[j], 32 + j);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); #1;
      checks++;
      if (b_bubble_cnt !== 3'((i + 1 > 7) ? 7 : i + 1) || b_bubble_cnt !== b_bubble) begin
        failures++; $display("FAIL sat_bubble i=%0d got=%0d exp=%0d", i, b_bubble_cnt, (i + 1 > 7) ? 7 : i + 1);
      end
    end
    checks++;
    if (b_stall_cnt !== 3'd0 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL sat_stall got s=%0d v=%0b exp s=0 v=0", b_stall_cnt, b_out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_in_valid  = 1'b1;
      a_in_ctrl   = 16'h0E0 + 16'(i);
      a_in_data   = $urandom;
      a_out_ready = (i == 0);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_ctrl} !== {1'b1, 1'b0, 16'h0E0}) begin
      failures++; $display("FAIL areset_pre got v=%0b r=%0b c=%0h exp v=1 r=0 c=e0", a_out_valid, a_in_ready, a_out_ctrl);
    end
    #1; rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_ctrl, a_stall_cnt, a_bubble_cnt} !== {1'b0, 1'b1, 16'h0, 32'h0}) begin
      failures++; $display("FAIL areset got v=%0b r=%0b c=%0h s=%0d b=%0d exp v=0 r=1 c=0 s=0 b=0", a_out_valid, a_in_ready, a_out_ctrl, a_stall_cnt, a_bubble_cnt);
    end
    @(negedge clk); rst = 1'b0;
    a_out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_ctrl   = 16'($urandom);
      a_in_data   = $urandom;
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 15) == 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_ctrl   = 16'($urandom);
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_ctrl} !== {ea_valid(), ea_ready(), ea_ctrl()} || (ea_valid() && a_out_data !== ea_data())) begin
        failures++; $display("FAIL rand_a i=%0d got v=%0b r=%0b c=%0h d=%0h exp v=%0b r=%0b c=%0h d=%0h", i, a_out_valid, a_in_ready, a_out_ctrl, a_out_data, ea_valid(), ea_ready(), ea_ctrl(), ea_data());
      end
      checks++;
      if (a_stall_cnt !== a_stall || a_bubble_cnt !== a_bubble) begin
        failures++; $display("FAIL rand_a_cnt i=%0d got s=%0d b=%0d exp s=%0d b=%0d", i, a_stall_cnt, a_bubble_cnt, a_stall, a_bubble);
      end
      checks++;
      if ({b_out_valid, b_in_ready, b_out_ctrl} !== {eb_valid(), eb_ready(), eb_ctrl()} || (eb_valid() && b_out_data !== eb_data())) begin
        failures++; $display("FAIL rand_b i=%0d got v=%0b r=%0b c=%0h exp v=%0b r=%0b c=%0h", i, b_out_valid, b_in_ready, b_out_ctrl, eb_valid(), eb_ready(), eb_ctrl());
      end
      checks++;
      if (b_stall_cnt !== b_stall || b_bubble_cnt !== b_bubble) begin
        failures++; $display("FAIL rand_b_cnt i=%0d got s=%0d b=%0d exp s=%0d b=%0d", i, b_stall_cnt, b_bubble_cnt, b_stall, b_bubble);
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
